prbs31_checker_32: RTL and testbench

- Downstream consumer of the 32-bit error-injection stage in the 25G PCS testbench.
- Receives the possibly-corrupted PRBS31 word stream every clock.
- Self-synchronises to the stream, then free-runs a local PRBS31 reference and counts bit errors, errored words and lock losses.
- Used to measure the BER produced by each injection mode.

---
 rtl/prbs31_checker_32.sv | 162 ++++++++++++++++
 tb/tb_prbs31_checker_32.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker_32.sv
// PRBS31 checker for a 32-bit word stream. It seeds itself from the received data,
// qualifies lock over LOCK_CNT clean words, then free-runs a local reference and
// counts errored bits, errored words and lock losses. Counters saturate at all-ones.
module prbs31_checker_32 #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_WIN = 64,
  parameter int UNLOCK_ERR = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_clear,
  input  logic [31:0]      ind,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] word_err_cnt,
  output logic [CNT_W-1:0] lock_loss_cnt
);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(UNLOCK_WIN);
  localparam int BAD_W  = $clog2(UNLOCK_ERR + 1);
  // Sum must hold a full 32-bit popcount even for narrow counters.
  localparam int SUM_W  = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t            state_reg, state_next;
  logic [30:0]       lfsr_reg, lfsr_next;
  logic [GOOD_W-1:0] good_reg, good_next;
  logic [31:0]       err_vec_q, err_vec_next;
  logic              chk_q, chk_next;
  logic [WIN_W-1:0]  win_reg;
  logic [BAD_W-1:0]  bad_reg;
  logic [31:0]       exp_word;
  logic              match, enter_locked, err_now, unlock;
  logic [5:0]        err_bits;
  logic [SUM_W-1:0]  bit_sum;

  // 32 next bits of b[n] = b[n-31] ^ b[n-28]; s[30] is the most recent bit and
  // output bit 0 is the earliest generated bit.
  function automatic logic [31:0] next32(input logic [30:0] s);
    logic [62:0] e;
    e = {32'b0, s};
    for (int i = 0; i < 32; i++) e[31+i] = e[i] ^ e[i+3];
    return e[62:31];
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'b0, v[i]};
    return c;
  endfunction

  assign exp_word = next32(lfsr_reg);
  // The all-zero word is the LFSR lock-up state and never counts as a match.
  assign match    = (ind == exp_word) && (ind != 32'd0);
  assign err_now  = chk_q && (err_vec_q != 32'd0);
  assign unlock   = err_now && (bad_reg == BAD_W'(UNLOCK_ERR - 1));
  assign err_bits = popcount32(err_vec_q);
  assign bit_sum  = SUM_W'(bit_err_cnt) + SUM_W'(err_bits);
  assign locked   = (state_reg == LOCKED);

  // Next-state logic: reseed from data while acquiring, free-run once locked.
  always_comb begin
    state_next   = state_reg;
    lfsr_next    = lfsr_reg;
    good_next    = good_reg;
    err_vec_next = '0;
    chk_next     = 1'b0;
    enter_locked = 1'b0;
    case (state_reg)
      HUNT: begin
        lfsr_next = ind[31:1];
        good_next = '0;
        if (ind[31:1] != 31'd0) state_next = CHECK;
      end
      CHECK: begin
        lfsr_next = ind[31:1];
        if (match) begin
          if (good_reg == GOOD_W'(LOCK_CNT - 1)) begin
            state_next   = LOCKED;
            good_next    = '0;
            enter_locked = 1'b1;
          end else begin
            good_next = good_reg + GOOD_W'(1);
          end
        end else begin
          good_next = '0;
        end
      end
      LOCKED: begin
        lfsr_next    = exp_word[31:1];
        err_vec_next = ind ^ exp_word;
        chk_next     = 1'b1;
        // Losing lock discards the word sampled on this same edge.
        if (unlock) begin
          state_next   = HUNT;
          chk_next     = 1'b0;
          err_vec_next = '0;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // State, reference history and compare pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= HUNT;
      lfsr_reg  <= '0;
      good_reg  <= '0;
      err_vec_q <= '0;
      chk_q     <= 1'b0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      good_reg  <= good_next;
      err_vec_q <= err_vec_next;
      chk_q     <= chk_next;
    end
  end

  // Unlock window: the wrapping word's error still belongs to the old window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_reg <= '0;
      bad_reg <= '0;
    end else if (enter_locked || (chk_q && (unlock || win_reg == WIN_W'(UNLOCK_WIN - 1)))) begin
      win_reg <= '0;
      bad_reg <= '0;
    end else if (chk_q) begin
      win_reg <= win_reg + WIN_W'(1);
      bad_reg <= bad_reg + BAD_W'(err_now);
    end
  end

  // Statistics: in_clear beats a same-cycle increment; counters clamp at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse     <= 1'b0;
      bit_err_cnt   <= '0;
      word_err_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else begin
      err_pulse <= err_now;
      if (in_clear) begin
        bit_err_cnt   <= '0;
        word_err_cnt  <= '0;
        lock_loss_cnt <= '0;
      end else begin
        if (err_now) begin
          bit_err_cnt <= (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
          if (word_err_cnt != CNT_MAX) word_err_cnt <= word_err_cnt + CNT_W'(1);
        end
        if (unlock && lock_loss_cnt != CNT_MAX) lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_prbs31_checker_32.sv
// Bench for prbs31_checker_32: a bit-serial PRBS31 source drives both a full-width
// checker and a 4-bit-counter copy; a scoreboard tracks errored words per cycle.
module tb_prbs31_checker_32;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_clear = 1'b0;
  logic [31:0] ind = '0;
  logic        locked, err_pulse;
  logic [31:0] bit_err_cnt, word_err_cnt, lock_loss_cnt;
  logic        s_locked, s_err_pulse;
  logic [3:0]  s_bit_err_cnt, s_word_err_cnt, s_lock_loss_cnt;

  prbs31_checker_32 dut (
    .clk(clk), .reset_n(reset_n), .in_clear(in_clear), .ind(ind),
    .locked(locked), .err_pulse(err_pulse), .bit_err_cnt(bit_err_cnt),
    .word_err_cnt(word_err_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  prbs31_checker_32 #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_clear(in_clear), .ind(ind),
    .locked(s_locked), .err_pulse(s_err_pulse), .bit_err_cnt(s_bit_err_cnt),
    .word_err_cnt(s_word_err_cnt), .lock_loss_cnt(s_lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit counted; int bits; } sb_t;
  typedef struct { logic [31:0] mask; logic clr; longint bits; longint words; } vec_t;

  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4  = 15;

  sb_t         sbq[$];
  vec_t        tbl[8];
  int          n_cmp = 0;
  int          n_fail = 0;
  longint      mb = 0;
  longint      mw = 0;
  logic [30:0] hist;
  int          lock_words = 0;
  bit          fell;

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Serial reference: one bit at a time from b[n] = b[n-31] ^ b[n-28].
  task automatic gen(output logic [31:0] w);
    logic nb;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      nb   = hist[0] ^ hist[3];
      w[i] = nb;
      hist = {nb, hist[30:1]};
    end
  endtask

  // Drive one word (clean ^ mask); expectation queued now, scored one edge later.
  task automatic step(input logic [31:0] w, input logic [31:0] m, input logic clr,
                      input bit counted);
    sb_t e;
    bit  hit;
    ind      = w ^ m;
    in_clear = clr;
    e.counted = counted;
    e.bits    = $countones(m);
    sbq.push_back(e);
    if (counted) lock_words++;
    @(posedge clk);
    #1;
    if (sbq.size() > 1) begin
      e   = sbq.pop_front();
      hit = e.counted && (e.bits != 0);
      if (clr) begin
        mb = 0;
        mw = 0;
      end else if (hit) begin
        mw = sat(mw + 1, MAX32);
        mb = sat(mb + e.bits, MAX32);
      end
      check("err_pulse", err_pulse, hit ? 1 : 0);
    end
  endtask

  task automatic clean_step(input logic clr, input bit counted);
    logic [31:0] w;
    gen(w);
    step(w, 32'd0, clr, counted);
  endtask

  initial begin
    logic [31:0] w;
    tbl[0] = '{32'h0002_0000, 1'b0, 1,  1};
    tbl[1] = '{32'h0000_000F, 1'b0, 5,  2};
    tbl[2] = '{32'h8000_0001, 1'b0, 7,  3};
    tbl[3] = '{32'h0000_0000, 1'b0, 7,  3};
    tbl[4] = '{32'hFFFF_FFFF, 1'b0, 39, 4};
    tbl[5] = '{32'h0001_0000, 1'b1, 0,  0};
    tbl[6] = '{32'h0F0F_0000, 1'b0, 8,  1};
    tbl[7] = '{32'h0000_0001, 1'b1, 0,  0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_bit_cnt", bit_err_cnt, 0);
    check("rst_word_cnt", word_err_cnt, 0);
    check("rst_loss_cnt", lock_loss_cnt, 0);
    reset_n = 1'b1;
    $display("reset released");

    // All-zero input must never acquire.
    for (int i = 0; i < 1000; i++) step(32'd0, 32'd0, 1'b0, 1'b0);
    check("zero_locked", locked, 0);
    check("zero_bit_cnt", bit_err_cnt, 0);
    check("zero_word_cnt", word_err_cnt, 0);
    $display("zero input: 1000 words, locked=%0b", locked);

    // Acquisition from seed all-ones: lock after the 17th word.
    hist = 31'h7FFF_FFFF;
    for (int i = 0; i < 16; i++) clean_step(1'b0, 1'b0);
    check("acq_locked_w16", locked, 0);
    clean_step(1'b0, 1'b0);
    check("acq_locked_w17", locked, 1);
    lock_words = 0;
    for (int i = 0; i < 10000; i++) clean_step(1'b0, 1'b1);
    check("clean_locked", locked, 1);
    check("clean_bit_cnt", bit_err_cnt, 0);
    check("clean_word_cnt", word_err_cnt, 0);
    check("clean_loss_cnt", lock_loss_cnt, 0);
    $display("clean run: 10000 words, bits=%0d words=%0d", bit_err_cnt, word_err_cnt);

    // Low nibble zeroed on one word in every 129.
    fell = 1'b0;
    for (int i = 0; i < 12900; i++) begin
      gen(w);
      step(w, ((i % 129) == 128) ? {28'd0, w[3:0]} : 32'd0, 1'b0, 1'b1);
      if (!locked) fell = 1'b1;
    end
    check("mode01_lock_held", fell, 0);
    check("mode01_bit_cnt", bit_err_cnt, mb);
    check("mode01_word_cnt", word_err_cnt, mw);
    check("sat_bit_cnt", s_bit_err_cnt, sat(mb, MAX4));
    check("sat_word_cnt", s_word_err_cnt, sat(mw, MAX4));
    $display("mode01: bits=%0d words=%0d", bit_err_cnt, word_err_cnt);

    // Eight inverted words at the start of a window force loss of lock.
    while ((lock_words % 64) != 0) clean_step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      gen(w);
      step(w, 32'hFFFF_FFFF, 1'b0, 1'b1);
    end
    check("burst_locked_w8", locked, 1);
    clean_step(1'b0, 1'b0);
    check("burst_unlocked", locked, 0);
    check("burst_loss_cnt", lock_loss_cnt, 1);
    check("burst_bit_cnt", bit_err_cnt, mb);
    check("burst_word_cnt", word_err_cnt, mw);
    for (int i = 0; i < 16; i++) clean_step(1'b0, 1'b0);
    check("relock_w16", locked, 0);
    clean_step(1'b0, 1'b0);
    check("relock_w17", locked, 1);
    lock_words = 0;
    $display("burst: lock_loss=%0d relocked=%0b", lock_loss_cnt, locked);

    // Clear everything, then single-word error vectors.
    clean_step(1'b1, 1'b1);
    check("clear_loss_cnt", lock_loss_cnt, 0);
    check("clear_locked", locked, 1);
    for (int r = 0; r < 8; r++) begin
      gen(w);
      step(w, tbl[r].mask, 1'b0, 1'b1);
      clean_step(tbl[r].clr, 1'b1);
      check("vec_locked", locked, 1);
      check("vec_bit_cnt", bit_err_cnt, tbl[r].bits);
      check("vec_word_cnt", word_err_cnt, tbl[r].words);
      check("vec_sat_bit_cnt", s_bit_err_cnt, sat(tbl[r].bits, MAX4));
      check("vec_sat_word_cnt", s_word_err_cnt, sat(tbl[r].words, MAX4));
      $display("vec %0d mask=%h clr=%0b bits=%0d words=%0d", r, tbl[r].mask, tbl[r].clr,
               bit_err_cnt, word_err_cnt);
    end

    // Asynchronous reset in the middle of a locked run.
    while ((lock_words % 64) != 0) clean_step(1'b0, 1'b1);
    gen(w);
    step(w, 32'h0000_0020, 1'b0, 1'b1);
    clean_step(1'b0, 1'b1);
    check("prerst_word_cnt", word_err_cnt, 1);
    check("prerst_locked", locked, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_err_pulse", err_pulse, 0);
    check("arst_bit_cnt", bit_err_cnt, 0);
    check("arst_word_cnt", word_err_cnt, 0);
    check("arst_loss_cnt", lock_loss_cnt, 0);
    check("arst_sat_word_cnt", s_word_err_cnt, 0);
    sbq.delete();
    $display("async reset: locked=%0b words=%0d", locked, word_err_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
